// File: rtl/stream_replay_pkg.sv
// Shared constants for the stream replay block: FSM encodings, CSR map and bit positions.
package stream_replay_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [3:0] CSR_CTRL   = 4'd0;
  localparam logic [3:0] CSR_STATUS = 4'd1;
  localparam logic [3:0] CSR_BASE   = 4'd2;
  localparam logic [3:0] CSR_COUNT  = 4'd3;
  localparam logic [3:0] CSR_SENT   = 4'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_LOOP    = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  localparam int PAYLOAD_W = 36;
endpackage

// File: rtl/stream_replay_fifo.sv
// First-word-fall-through buffer for returned read data, with occupancy and a flush.
module replay_fifo
  import stream_replay_pkg::*;
#(
  parameter int W     = PAYLOAD_W,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     used
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      used <= used + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: nothing is read until used goes non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (used == '0);
endmodule

// File: rtl/stream_replay.sv
// Replays captured 64-bit words from memory as a 36-bit stream; CSR-controlled, one-shot or looping.
module stream_replay
  import stream_replay_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 20,
  parameter int CNT_W      = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        csr_address,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [63:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [35:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready
);
  localparam int FAW  = $clog2(FIFO_DEPTH);
  localparam int WA_W = ADDR_W - 3;

  logic [1:0]       state;
  logic [WA_W-1:0]  base_q;
  logic [CNT_W-1:0] count_q, issued;
  logic             loop_q, done_q, aborted_q, stall_hold;
  logic [31:0]      sent_q, rd_mux;
  logic [FAW:0]     inflight, fifo_used;
  logic [FAW+1:0]   occupancy;
  logic             fifo_empty, credit_ok, accept, issue_acc, last_issue;
  logic             rdv_take, push, pop, flush;
  logic [35:0]      fifo_data;
  logic             ctrl_wr, start_req, abort_req;
  logic             unused_bits;

  assign ctrl_wr   = csr_write && (csr_address == CSR_CTRL);
  assign start_req = ctrl_wr && csr_writedata[CTRL_START] && !csr_writedata[CTRL_ABORT] && (state == S_IDLE);
  assign abort_req = ctrl_wr && csr_writedata[CTRL_ABORT] && ((state == S_RUN) || (state == S_DRAIN));

  // Credit covers both outstanding reads and buffered words, so returns can never overflow the FIFO.
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_used};
  assign credit_ok = occupancy < (FAW+2)'(FIFO_DEPTH);
  // stall_hold keeps a stalled request on the bus even if an abort lands mid-stall.
  assign mem_read    = ((state == S_RUN) && (issued < count_q) && credit_ok) || stall_hold;
  assign mem_address = {base_q + WA_W'(issued), 3'b000};
  assign accept      = mem_read && !mem_waitrequest;
  assign issue_acc   = accept && (state == S_RUN);
  assign last_issue  = (issued + CNT_W'(1)) == count_q;

  assign rdv_take = mem_readdatavalid && (inflight != '0);
  assign push     = rdv_take && ((state == S_RUN) || (state == S_DRAIN));
  assign flush    = (state == S_FLUSH);
  assign st_valid = !fifo_empty && (state != S_FLUSH);
  assign pop      = st_valid && st_ready;
  assign st_data  = st_valid ? fifo_data : '0;

  assign unused_bits = ^{mem_readdata[63:36], csr_writedata[31:ADDR_W]};

  replay_fifo #(.W(36), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (mem_readdata[35:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .used      (fifo_used)
  );

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_CTRL:   rd_mux[CTRL_LOOP] = loop_q;
      CSR_STATUS: begin
        rd_mux[STAT_BUSY]    = (state != S_IDLE);
        rd_mux[STAT_DONE]    = done_q;
        rd_mux[STAT_ABORTED] = aborted_q;
      end
      CSR_BASE:   rd_mux[ADDR_W-1:3] = base_q;
      CSR_COUNT:  rd_mux[CNT_W-1:0]  = count_q;
      CSR_SENT:   rd_mux = sent_q;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      issued       <= '0;
      loop_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      stall_hold   <= 1'b0;
      sent_q       <= '0;
      inflight     <= '0;
      csr_readdata <= '0;
    end else begin
      csr_readdata <= csr_read ? rd_mux : '0;
      stall_hold   <= mem_read && mem_waitrequest;
      inflight     <= inflight + (FAW+1)'(accept) - (FAW+1)'(rdv_take);
      if (pop) sent_q <= sent_q + 32'd1;

      if (ctrl_wr) loop_q <= csr_writedata[CTRL_LOOP];
      if (csr_write && (csr_address == CSR_STATUS)) begin
        if (csr_writedata[STAT_DONE])    done_q    <= 1'b0;
        if (csr_writedata[STAT_ABORTED]) aborted_q <= 1'b0;
      end
      if (csr_write && (csr_address == CSR_BASE) && (state == S_IDLE))
        base_q <= csr_writedata[ADDR_W-1:3];
      if (csr_write && (csr_address == CSR_COUNT) && (state == S_IDLE))
        count_q <= csr_writedata[CNT_W-1:0];

      // FSM status updates come last so a completion wins over a same-cycle W1C.
      case (state)
        S_IDLE: if (start_req) begin
          sent_q <= '0;
          issued <= '0;
          if (count_q == '0) done_q <= 1'b1;
          else               state  <= S_RUN;
        end
        S_RUN: begin
          if (issue_acc) issued <= (last_issue && loop_q) ? '0 : issued + CNT_W'(1);
          if (abort_req)                            state <= S_FLUSH;
          else if (issue_acc && last_issue && !loop_q) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (abort_req) state <= S_FLUSH;
          else if ((inflight == '0) && fifo_empty) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: if ((inflight == '0) && !mem_read) begin
          state     <= S_IDLE;
          aborted_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stream_replay.sv
// Directed bench for stream_replay: Avalon-MM memory model with stalls/latency, stream sink, CSR tasks.
module tb_stream_replay;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  csr_address = '0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic [19:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [63:0] mem_readdata = '0;
  logic        mem_readdatavalid = 1'b0;
  logic [35:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  stream_replay #(.FIFO_DEPTH(16), .ADDR_W(20), .CNT_W(17)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] payload(input logic [19:0] a);
    return {a[15:0] ^ 16'h3C5A, a};
  endfunction
  function automatic logic [63:0] mem_word(input logic [19:0] a);
    return {a ^ 20'hFEED0, 8'hA5, payload(a)};
  endfunction

  typedef struct { logic [19:0] a; int due; } req_t;
  req_t        pend[$];
  logic [19:0] acc_addr[$];
  int          acc_cyc[$];
  logic [35:0] got[$];
  int          got_cyc[$];
  int cyc = 0, outstanding = 0, max_out = 0, stall_viol = 0;
  int first_rdv = -1, first_vld = -1;
  int wait_pct = 0, dly_max = 0, ready_low_until = 0;
  bit prev_stall = 0;
  logic [19:0] prev_addr = '0;

  // Memory slave + stream sink, all driven and sampled on the falling edge.
  always @(negedge clk) begin
    req_t r;
    cyc++;
    if (!reset_n) begin
      pend.delete();
      mem_readdatavalid = 1'b0;
      mem_waitrequest   = 1'b0;
      prev_stall        = 0;
      outstanding       = 0;
      st_ready          = 1'b0;
    end else begin
      if (prev_stall && (mem_read !== 1'b1 || mem_address !== prev_addr)) stall_viol++;
      mem_readdatavalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        mem_readdata      = mem_word(r.a);
        mem_readdatavalid = 1'b1;
        if (first_rdv < 0) first_rdv = cyc;
      end
      mem_waitrequest = (wait_pct > 0) && ($urandom_range(99) < wait_pct);
      prev_stall = mem_read && mem_waitrequest;
      prev_addr  = mem_address;
      if (mem_read && !mem_waitrequest) begin
        r.a = mem_address;
        r.due = cyc + 1 + $urandom_range(dly_max);
        pend.push_back(r);
        acc_addr.push_back(mem_address);
        acc_cyc.push_back(cyc);
        outstanding++;
      end
      st_ready = (cyc >= ready_low_until);
      if (st_valid && first_vld < 0) first_vld = cyc;
      if (st_valid && st_ready) begin
        got.push_back(st_data);
        got_cyc.push_back(cyc);
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] s;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      csr_rd(4'd1, s);
      if (!s[0]) begin ok = 1; break; end
    end
  endtask

  task automatic clear_log();
    acc_addr.delete(); acc_cyc.delete(); got.delete(); got_cyc.delete();
    max_out = 0; stall_viol = 0; first_rdv = -1; first_vld = -1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_address !== 20'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
    checks++; if (st_valid !== 1'b0 || st_data !== 36'h0) begin errors++; $display("FAIL reset_st: got v=%b d=%h want 0/0", st_valid, st_data); end
    checks++; if (csr_readdata !== 32'h0) begin errors++; $display("FAIL reset_csr_readdata: got %h want 0", csr_readdata); end
    reset_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      csr_rd(4'(a), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_csr%0d: got %h want 0", a, d); end
    end
  endtask

  task automatic test_basic();
    logic [19:0] ea [4] = '{20'h00080, 20'h00088, 20'h00090, 20'h00098};
    logic [31:0] d; bit ok;
    clear_log();
    csr_wr(4'd2, 32'h80);
    csr_wr(4'd3, 32'd4);
    csr_wr(4'd0, 32'h1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got busy want idle"); end
    checks++; if (acc_addr.size() != 4) begin errors++; $display("FAIL basic_reads: got %0d want 4", acc_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc_addr[i] !== ea[i]) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, acc_addr[i], ea[i]); end
      checks++; if (got[i] !== payload(ea[i])) begin errors++; $display("FAIL basic_data%0d: got %h want %h", i, got[i], payload(ea[i])); end
    end
    checks++; if (first_vld - first_rdv != 1) begin errors++; $display("FAIL basic_first_latency: got %0d want 1", first_vld - first_rdv); end
    checks++; if (acc_cyc[3] - acc_cyc[0] != 3) begin errors++; $display("FAIL basic_issue_rate: got %0d want 3", acc_cyc[3] - acc_cyc[0]); end
    checks++; if (got_cyc[3] - got_cyc[0] != 3) begin errors++; $display("FAIL basic_out_rate: got %0d want 3", got_cyc[3] - got_cyc[0]); end
    csr_rd(4'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_status: got %h want 2", d); end
    csr_rd(4'd4, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL basic_sent: got %0d want 4", d); end
    csr_wr(4'd1, 32'h6);
    csr_rd(4'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_w1c: got %h want 0", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; bit ok;
    clear_log();
    csr_wr(4'd2, 32'h800);
    csr_wr(4'd3, 32'd40);
    ready_low_until = cyc + 50;
    csr_wr(4'd0, 32'h1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got busy want idle"); end
    checks++; if (max_out > 16) begin errors++; $display("FAIL bp_credit: got %0d want <=16", max_out); end
    checks++; if (got.size() != 40) begin errors++; $display("FAIL bp_count: got %0d want 40", got.size()); end
    for (int i = 0; i < 40; i++) begin
      checks++; if (got[i] !== payload(20'h800 + 20'(8*i))) begin errors++; $display("FAIL bp_data%0d: got %h want %h", i, got[i], payload(20'h800 + 20'(8*i))); end
    end
    csr_rd(4'd4, d);
    checks++; if (d !== 32'd40) begin errors++; $display("FAIL bp_sent: got %0d want 40", d); end
    csr_wr(4'd1, 32'h6);
  endtask

  task automatic test_stalls();
    bit ok;
    clear_log();
    wait_pct = 50; dly_max = 7;
    csr_wr(4'd2, 32'h10000);
    csr_wr(4'd3, 32'd12);
    csr_wr(4'd0, 32'h1);
    wait_idle(ok);
    wait_pct = 0; dly_max = 0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got busy want idle"); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol); end
    checks++; if (got.size() != 12) begin errors++; $display("FAIL stall_count: got %0d want 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (got[i] !== payload(20'h10000 + 20'(8*i))) begin errors++; $display("FAIL stall_data%0d: got %h want %h", i, got[i], payload(20'h10000 + 20'(8*i))); end
    end
    csr_wr(4'd1, 32'h6);
  endtask

  task automatic test_addr_wrap();
    logic [19:0] ea [4] = '{20'hFFFF0, 20'hFFFF8, 20'h00000, 20'h00008};
    bit ok;
    clear_log();
    csr_wr(4'd2, 32'hFFFF0);
    csr_wr(4'd3, 32'd4);
    csr_wr(4'd0, 32'h1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got busy want idle"); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, acc_addr[i], ea[i]); end
      checks++; if (got[i] !== payload(ea[i])) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", i, got[i], payload(ea[i])); end
    end
    csr_wr(4'd1, 32'h6);
  endtask

  task automatic test_loop_abort();
    logic [19:0] ea [3] = '{20'h00200, 20'h00208, 20'h00210};
    logic [31:0] d; bit ok; int n;
    clear_log();
    csr_wr(4'd2, 32'h200);
    csr_wr(4'd3, 32'd3);
    csr_wr(4'd0, 32'h5);
    for (int i = 0; i < 500 && got.size() < 10; i++) @(negedge clk);
    checks++; if (got.size() < 10) begin errors++; $display("FAIL loop_progress: got %0d words want >=10", got.size()); end
    csr_wr(4'd0, 32'h2);
    checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL loop_flush_valid: got %b want 0", st_valid); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_timeout: got busy want idle"); end
    n = got.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (got[i] !== payload(ea[i%3])) begin errors++; $display("FAIL loop_data%0d: got %h want %h", i, got[i], payload(ea[i%3])); end
    end
    csr_rd(4'd1, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL loop_status: got %h want 4", d); end
    csr_rd(4'd4, d);
    checks++; if (d !== 32'(n)) begin errors++; $display("FAIL loop_sent: got %0d want %0d", d, n); end
    checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL loop_idle_valid: got %b want 0", st_valid); end
    csr_wr(4'd1, 32'h6);
  endtask

  task automatic test_zero_count_and_reset();
    logic [31:0] d;
    clear_log();
    csr_wr(4'd3, 32'd0);
    csr_wr(4'd0, 32'h1);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL zero_mem_read: got %b want 0", mem_read); end
    csr_rd(4'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL zero_status: got %h want 2", d); end
    checks++; if (acc_addr.size() != 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", acc_addr.size()); end
    csr_wr(4'd1, 32'h6);
    csr_wr(4'd2, 32'h1800);
    csr_wr(4'd3, 32'd40);
    ready_low_until = cyc + 1000;
    csr_wr(4'd0, 32'h1);
    repeat (10) @(negedge clk);
    checks++; if (st_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", st_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_address !== 20'h0) begin errors++; $display("FAIL rst_mem: got r=%b a=%h want 0/0", mem_read, mem_address); end
    checks++; if (st_valid !== 1'b0 || st_data !== 36'h0) begin errors++; $display("FAIL rst_st: got v=%b d=%h want 0/0", st_valid, st_data); end
    checks++; if (csr_readdata !== 32'h0) begin errors++; $display("FAIL rst_csr: got %h want 0", csr_readdata); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ready_low_until = 0;
    repeat (2) @(negedge clk);
    csr_rd(4'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count: got %h want 0", d); end
    csr_rd(4'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stalls();
    test_addr_wrap();
    test_loop_abort();
    test_zero_count_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
